pipe_stage_skid: RTL and testbench

//  Generic valid/ready pipeline stage register; successor to the fixed per-stage latches (IF/ID, ID/EX, EX/DM, DM/WB).

---
 rtl/pipe_stage_skid_pkg.sv | 25 ++
 rtl/pipe_sat_counter.sv | 22 ++
 rtl/pipe_stage_skid.sv | 124 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants for valid/ready pipeline stages: control bundle layout and
// an occupancy helper used by pipe_stage_skid.
package pipe_stage_skid_pkg;

    localparam int PIPE_CTRL_W = 16;

    // Bit offsets inside the control bundle; stage wrappers pack/unpack with these.
    localparam int CTRL_RF_WEN = 0;
    localparam int CTRL_DM_WEN = 1;
    localparam int CTRL_MEM_OP = 2;
    localparam int CTRL_HALT   = 4;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic logic [1:0] occ_next(input logic [1:0] occ,
                                            input logic       acc,
                                            input logic       emit);
        return occ + {1'b0, acc} - {1'b0, emit};
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stat_clr
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              accept;
    logic              emit;

    assign accept    = in_valid && in_ready;
    assign emit      = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    // Gate ctrl on bubbles so a stale write enable never reaches the next stage.
    assign out_ctrl  = main_valid ? main_ctrl : '0;

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_valid;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;

            // Registered ready: no combinational path from out_ready to in_ready.
            assign in_ready = !skid_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    main_data  <= '0;
                    main_ctrl  <= '0;
                    skid_valid <= 1'b0;
                    skid_data  <= '0;
                    skid_ctrl  <= '0;
                    occupancy  <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                    occupancy  <= '0;
                end else begin
                    if (emit) begin
                        if (skid_valid) begin
                            main_data  <= skid_data;
                            main_ctrl  <= skid_ctrl;
                            skid_valid <= 1'b0;
                        end else if (accept) begin
                            main_data <= in_data;
                            main_ctrl <= in_ctrl;
                        end else begin
                            main_valid <= 1'b0;
                        end
                    end else if (accept) begin
                        if (!main_valid) begin
                            main_valid <= 1'b1;
                            main_data  <= in_data;
                            main_ctrl  <= in_ctrl;
                        end else begin
                            skid_valid <= 1'b1;
                            skid_data  <= in_data;
                            skid_ctrl  <= in_ctrl;
                        end
                    end
                    occupancy <= occ_next(occupancy, accept, emit);
                end
            end
        end else begin : g_single
            assign in_ready = out_ready || !main_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    main_data  <= '0;
                    main_ctrl  <= '0;
                    occupancy  <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    occupancy  <= '0;
                end else begin
                    if (accept) begin
                        main_valid <= 1'b1;
                        main_data  <= in_data;
                        main_ctrl  <= in_ctrl;
                    end else if (emit) begin
                        main_valid <= 1'b0;
                    end
                    occupancy <= occ_next(occupancy, accept, emit);
                end
            end
        end
    endgenerate

    pipe_sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (main_valid && !out_ready),
        .clr  (stat_clr),
        .cnt  (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: DUT A is SKID=1/CNT_W=4, DUT B is SKID=0/CNT_W=16; both are
// compared each cycle against a FIFO-of-entries reference model.
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, in_valid_a, in_ready_a, flush_a, out_valid_a, out_ready_a, stat_clr_a;
    logic [31:0] in_data_a, out_data_a;
    logic [15:0] in_ctrl_a, out_ctrl_a;
    logic [1:0]  occ_a;
    logic [3:0]  stall_a;

    logic        rst_n_b, in_valid_b, in_ready_b, flush_b, out_valid_b, out_ready_b, stat_clr_b;
    logic [31:0] in_data_b, out_data_b;
    logic [15:0] in_ctrl_b, out_ctrl_b;
    logic [1:0]  occ_b;
    logic [15:0] stall_b;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .in_ctrl(in_ctrl_a), .flush(flush_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_ctrl(out_ctrl_a), .occupancy(occ_a), .stall_cnt(stall_a), .stat_clr(stat_clr_a)
    );

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .SKID(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .in_ctrl(in_ctrl_b), .flush(flush_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_ctrl(out_ctrl_b), .occupancy(occ_b), .stall_cnt(stall_b), .stat_clr(stat_clr_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage holds an ordered list of entries, capacity 2
    // (A) or 1 (B); the stall counter is a clamped integer.
    logic [47:0] q_a[$];
    logic [47:0] q_b[$];
    int unsigned mcnt_a = 0;
    int unsigned mcnt_b = 0;
    int emitted_a = 0;
    int emitted_b = 0;

    always @(negedge clk) begin
        logic [47:0] exp_e;
        if (!rst_n_a) begin
            q_a.delete();
            mcnt_a = 0;
            check("a_rst_out_valid", 64'(out_valid_a), 64'(0));
            check("a_rst_out_ctrl",  64'(out_ctrl_a),  64'(0));
            check("a_rst_occupancy", 64'(occ_a),       64'(0));
            check("a_rst_stall_cnt", 64'(stall_a),     64'(0));
            check("a_rst_in_ready",  64'(in_ready_a),  64'(1));
        end else begin
            check("a_occupancy", 64'(occ_a),       64'(q_a.size()));
            check("a_out_valid", 64'(out_valid_a), 64'(q_a.size() != 0));
            if (!out_valid_a) check("a_bubble_ctrl", 64'(out_ctrl_a), 64'(0));
            check("a_in_ready",  64'(in_ready_a),  64'(q_a.size() < 2));
            check("a_stall_cnt", 64'(stall_a),     64'(mcnt_a));
            if (stat_clr_a) mcnt_a = 0;
            else if (q_a.size() != 0 && !out_ready_a && mcnt_a < 15) mcnt_a++;
            if (flush_a) begin
                q_a.delete();
            end else begin
                if (out_valid_a && out_ready_a && q_a.size() != 0) begin
                    exp_e = q_a.pop_front();
                    check("a_data_order", 64'({out_data_a, out_ctrl_a}), 64'(exp_e));
                    emitted_a++;
                end
                if (in_valid_a && in_ready_a) q_a.push_back({in_data_a, in_ctrl_a});
            end
        end
    end

    always @(negedge clk) begin
        logic [47:0] exp_e;
        if (!rst_n_b) begin
            q_b.delete();
            mcnt_b = 0;
            check("b_rst_out_valid", 64'(out_valid_b), 64'(0));
            check("b_rst_occupancy", 64'(occ_b),       64'(0));
            check("b_rst_stall_cnt", 64'(stall_b),     64'(0));
        end else begin
            check("b_occupancy", 64'(occ_b),       64'(q_b.size()));
            check("b_occ_max",   64'(occ_b <= 2'd1), 64'(1));
            check("b_out_valid", 64'(out_valid_b), 64'(q_b.size() != 0));
            if (!out_valid_b) check("b_bubble_ctrl", 64'(out_ctrl_b), 64'(0));
            check("b_in_ready",  64'(in_ready_b),  64'(out_ready_b || q_b.size() == 0));
            check("b_stall_cnt", 64'(stall_b),     64'(mcnt_b));
            if (stat_clr_b) mcnt_b = 0;
            else if (q_b.size() != 0 && !out_ready_b && mcnt_b < 65535) mcnt_b++;
            if (flush_b) begin
                q_b.delete();
            end else begin
                if (out_valid_b && out_ready_b && q_b.size() != 0) begin
                    exp_e = q_b.pop_front();
                    check("b_data_order", 64'({out_data_b, out_ctrl_b}), 64'(exp_e));
                    emitted_b++;
                end
                if (in_valid_b && in_ready_b) q_b.push_back({in_data_b, in_ctrl_b});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid on DUT A until the entry is taken (bounded).
    task automatic send_a(input logic [31:0] d, input logic [15:0] c);
        logic acc;
        in_valid_a = 1'b1;
        in_data_a  = d;
        in_ctrl_a  = c;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc = in_ready_a;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL a_send_timeout: entry %0h not accepted within 50 cycles", d);
    endtask

    initial begin
        int e0;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        in_valid_a = 1'b1; in_data_a = 32'hDEAD_BEEF; in_ctrl_a = 16'h5A5A;
        flush_a = 1'b0; out_ready_a = 1'b0; stat_clr_a = 1'b0;
        in_valid_b = 1'b1; in_data_b = 32'hDEAD_BEEF; in_ctrl_b = 16'h5A5A;
        flush_b = 1'b0; out_ready_b = 1'b0; stat_clr_b = 1'b0;

        // Reset with a valid entry presented upstream
        repeat (3) cyc();
        check("t1_out_valid", 64'(out_valid_a), 64'(0));
        check("t1_out_ctrl",  64'(out_ctrl_a),  64'(0));
        check("t1_occupancy", 64'(occ_a),       64'(0));
        check("t1_stall_cnt", 64'(stall_a),     64'(0));
        check("t1_in_ready",  64'(in_ready_a),  64'(1));
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        cyc();

        // Streaming 1..8
        out_ready_a = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send_a(32'(i), 16'(i) | 16'h0100);
            check("t2_in_ready",  64'(in_ready_a),  64'(1));
            check("t2_out_valid", 64'(out_valid_a), 64'(1));
            check("t2_out_data",  64'(out_data_a),  64'(i));
        end
        in_valid_a = 1'b0;
        cyc();
        check("t2_drained", 64'(out_valid_a), 64'(0));

        // Backpressure A,B,C
        out_ready_a = 1'b0;
        e0 = emitted_a;
        send_a(32'h0000_000A, 16'h0001);
        send_a(32'h0000_000B, 16'h0002);
        in_valid_a = 1'b1; in_data_a = 32'h0000_000C; in_ctrl_a = 16'h0003;
        cyc(); cyc();
        check("t3_occupancy", 64'(occ_a),      64'(2));
        check("t3_in_ready",  64'(in_ready_a), 64'(0));
        check("t3_head_data", 64'(out_data_a), 64'(32'h0000_000A));
        check("t3_head_ctrl", 64'(out_ctrl_a), 64'(16'h0001));
        out_ready_a = 1'b1;
        send_a(32'h0000_000C, 16'h0003);
        in_valid_a = 1'b0;
        repeat (4) cyc();
        check("t3_emit_count", 64'(emitted_a - e0), 64'(3));

        // Flush with a full stage and a competing accept
        out_ready_a = 1'b0;
        send_a(32'h1111_0001, 16'h0011);
        send_a(32'h2222_0002, 16'h0022);
        check("t4_full", 64'(occ_a), 64'(2));
        in_valid_a = 1'b1; in_data_a = 32'h3333_0003; in_ctrl_a = 16'hFFFF;
        flush_a = 1'b1;
        cyc();
        flush_a = 1'b0; in_valid_a = 1'b0;
        check("t4_out_valid", 64'(out_valid_a), 64'(0));
        check("t4_out_ctrl",  64'(out_ctrl_a),  64'(0));
        check("t4_occupancy", 64'(occ_a),       64'(0));
        check("t4_data_kept", 64'(out_data_a),  64'(32'h1111_0001));
        cyc();
        check("t4_dropped", 64'(out_valid_a), 64'(0));

        // Stall counter saturation and clear
        stat_clr_a = 1'b1;
        cyc();
        stat_clr_a = 1'b0;
        check("t5_cleared", 64'(stall_a), 64'(0));
        send_a(32'h5555_0005, 16'h0055);
        in_valid_a = 1'b0;
        repeat (20) cyc();
        check("t5_saturated", 64'(stall_a), 64'(4'hF));
        stat_clr_a = 1'b1;
        cyc();
        stat_clr_a = 1'b0;
        check("t5_clr_priority", 64'(stall_a), 64'(0));
        out_ready_a = 1'b1;
        repeat (2) cyc();

        // Random traffic on both stages, with a mid-stream reset on A
        for (int i = 0; i < 10000; i++) begin
            in_valid_a  = ($urandom_range(0, 9) < 6);
            in_data_a   = $urandom;
            in_ctrl_a   = 16'($urandom);
            out_ready_a = ($urandom_range(0, 9) < 6);
            flush_a     = ($urandom_range(0, 39) == 0);
            stat_clr_a  = ($urandom_range(0, 96) == 0);
            rst_n_a     = !(i == 5000 || i == 5001);
            in_valid_b  = ($urandom_range(0, 1) == 1);
            in_data_b   = $urandom;
            in_ctrl_b   = 16'($urandom);
            out_ready_b = ($urandom_range(0, 1) == 1);
            flush_b     = ($urandom_range(0, 49) == 0);
            stat_clr_b  = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst_n_a = 1'b1;
        in_valid_a = 1'b0; out_ready_a = 1'b1; flush_a = 1'b0; stat_clr_a = 1'b0;
        in_valid_b = 1'b0; out_ready_b = 1'b1; flush_b = 1'b0; stat_clr_b = 1'b0;
        repeat (5) cyc();
        check("t6_a_empty", 64'(occ_a), 64'(0));
        check("t6_b_empty", 64'(occ_b), 64'(0));
        check("t6_b_progress", 64'(emitted_b > 1000), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
